// File: rtl/floor_call_if.sv
// floor_call_if: request/served handshake between the floor call encoder and
// the elevator controller.
//   req_valid    : encoder -> controller, req_floor holds an unissued call
//   req_floor    : encoder -> controller, BCD floor index
//   req_ready    : controller -> encoder, req_floor accepted this cycle
//   served_valid : controller -> encoder, a floor has been served
//   served_floor : controller -> encoder, BCD index of the served floor
// master = encoder side, slave = controller side.
interface floor_call_if;
  logic       req_valid;
  logic [3:0] req_floor;
  logic       req_ready;
  logic       served_valid;
  logic [3:0] served_floor;

  modport master (
    output req_valid, req_floor,
    input  req_ready, served_valid, served_floor
  );

  modport slave (
    input  req_valid, req_floor,
    output req_ready, served_valid, served_floor
  );
endinterface

// File: rtl/floor_call_encoder.sv
// floor_call_encoder: turns raw one-hot floor call buttons into a stream of
// BCD floor codes for the elevator controller.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   btn        : raw asynchronous call buttons, bit i = floor i
//   pending    : call-lamp register, bit i set while floor i is outstanding
//   bus        : floor_call_if.master (req_valid/req_floor/req_ready request
//                channel, served_valid/served_floor clear channel)
// Each button is synchronised (two flops) and debounced; a debounced rising
// edge latches the call into pending. Pending calls not yet issued are
// arbitrated into a single output register behind a valid/ready handshake.
// Optional macro FLOOR_CALL_RR_EN: round-robin arbitration starting after the
// last issued floor. Undefined: fixed lowest-index priority.
module floor_call_encoder #(
  parameter int N_FLOORS        = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] btn,
  output logic [N_FLOORS-1:0] pending,
  floor_call_if.master        bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_FLOORS-1:0] rise;

  // Per-button conditioning: synchroniser, debounce counter, edge detect.
  genvar gi;
  generate
    for (gi = 0; gi < N_FLOORS; gi++) begin : g_btn
      logic          sync1_reg, sync2_reg, deb_reg, deb_prev_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          deb_reg      <= 1'b0;
          deb_prev_reg <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= btn[gi];
          sync2_reg    <= sync1_reg;
          deb_prev_reg <= deb_reg;
          if (sync2_reg != deb_reg) begin
            // The level must disagree for DEBOUNCE_CYCLES consecutive
            // cycles; the flip happens on the cycle the count would reach it.
            if (cnt_reg == CNT_LAST) begin
              deb_reg <= sync2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign rise[gi] = deb_reg & ~deb_prev_reg;
    end
  endgenerate

  logic [N_FLOORS-1:0] pending_reg, pending_next;
  logic [N_FLOORS-1:0] issued_reg, issued_next;
  logic [N_FLOORS-1:0] served_mask, accept_mask, cand, set_mask;
  logic                req_valid_reg, req_valid_next;
  logic [3:0]          req_floor_reg, req_floor_next;
  logic                xfer, load, found;
  logic [3:0]          sel;
`ifdef FLOOR_CALL_RR_EN
  logic [3:0]          start_reg, start_next;
`endif

  always_comb begin
    xfer        = bus.req_valid & bus.req_ready;
    load        = ~bus.req_valid | bus.req_ready;
    served_mask = '0;
    accept_mask = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      // Out-of-range and non-BCD served codes never match any floor.
      served_mask[i] = bus.served_valid && (bus.served_floor == 4'(i));
      // The floor leaving the output register must not be reloaded at once.
      accept_mask[i] = xfer && (req_floor_reg == 4'(i));
    end
    cand  = pending_reg & ~issued_reg & ~accept_mask;
    found = 1'b0;
    sel   = '0;
`ifdef FLOOR_CALL_RR_EN
    for (int k = 0; k < N_FLOORS; k++) begin
      if (!found && cand[(int'(start_reg) + k) % N_FLOORS]) begin
        found = 1'b1;
        sel   = 4'((int'(start_reg) + k) % N_FLOORS);
      end
    end
`else
    // Descending scan so the lowest set index is the last one written.
    for (int k = N_FLOORS - 1; k >= 0; k--) begin
      if (cand[k]) begin
        found = 1'b1;
        sel   = 4'(k);
      end
    end
`endif
    set_mask = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      set_mask[i] = load && found && (sel == 4'(i));
    end

    // A served clear beats a press or an issue landing in the same cycle.
    pending_next = (pending_reg | rise) & ~served_mask;
    issued_next  = (issued_reg | set_mask) & ~served_mask;

    req_valid_next = req_valid_reg;
    req_floor_next = req_floor_reg;
    if (load) begin
      req_valid_next = found;
      if (found) begin
        req_floor_next = sel;
      end
    end
`ifdef FLOOR_CALL_RR_EN
    start_next = start_reg;
    if (load && found) begin
      start_next = (sel == 4'(N_FLOORS - 1)) ? 4'd0 : sel + 4'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      issued_reg    <= '0;
      req_valid_reg <= 1'b0;
      req_floor_reg <= 4'd0;
    end else begin
      pending_reg   <= pending_next;
      issued_reg    <= issued_next;
      req_valid_reg <= req_valid_next;
      req_floor_reg <= req_floor_next;
    end
  end

`ifdef FLOOR_CALL_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_reg <= 4'd0;
    end else begin
      start_reg <= start_next;
    end
  end
`endif

  assign pending       = pending_reg;
  assign bus.req_valid = req_valid_reg;
  assign bus.req_floor = req_floor_reg;

endmodule

// File: doc/floor_call_encoder.md
Name: floor_call_encoder

Overview:
- Input-side counterpart to the BCD-to-segment display path: converts raw one-hot floor call buttons into BCD floor codes for the elevator controller.
- Synchronises and debounces each button, then latches calls into a pending/lamp register.
- Arbitrates among pending calls and presents one BCD floor code at a time over a valid/ready handshake.
- Pending calls clear when the controller reports the floor as served.

Parameters:
- N_FLOORS, 8, number of floor buttons; legal range 2..10, so every floor index fits one BCD digit.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced level changes; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- btn  input  N_FLOORS  raw asynchronous call buttons, active-high, bit i = floor i
- req_ready  input  1  controller accepts req_floor this cycle
- served_valid  input  1  controller reports that a floor has been served
- served_floor  input  4  BCD index of the served floor
- req_valid  output  1  req_floor holds an unissued call
- req_floor  output  4  BCD floor index, 0..N_FLOORS-1
- pending  output  N_FLOORS  call-lamp register, bit i set while floor i is outstanding

Behaviour:
- Clocking and reset:
  - All state is clocked by clk and reset asynchronously while rst_n=0.
  - Reset values: req_valid=0, req_floor=4'd0, pending=0; issued, sync flops, debounce counters and debounced levels all 0.
  - Reset mid-operation discards all calls. A button still held when reset releases counts as a new press after debounce.
- Input conditioning, per button:
  - Two-flop synchroniser.
  - The debounce counter increments while the synchronised level differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES are rejected.
- Call latch:
  - A debounced rising edge on bit i sets pending[i] on the next clock. A repeat press on an already-pending floor has no effect.
  - Button release does not clear pending.
- Served:
  - served_valid=1 with served_floor<N_FLOORS clears pending[i] and issued[i] on the next clock.
  - served_floor>=N_FLOORS (including non-BCD 10..15) is ignored.
  - If a served clear and a press edge for the same floor arrive in the same cycle, the served clear wins and the press is dropped.
- Issue arbitration:
  - Candidate set = pending & ~issued.
  - The output register loads when it is empty (req_valid=0) or being emptied (req_valid & req_ready).
  - On load it takes the lowest-index candidate, excluding the floor being accepted this cycle. It sets req_valid=1, sets req_floor to that index in BCD, and sets issued for that index.
  - If there are no candidates, req_valid drops to 0 and req_floor holds its last value.
- Handshake rules:
  - A transfer occurs on a cycle with req_valid & req_ready.
  - While req_valid=1 and req_ready=0, req_floor is stable and req_valid stays high.
  - A served clear does not retract a presented request; the controller tolerates stale floors.
  - Back-to-back transfers sustain one per cycle when candidates exist.
- Latency: a btn rise held steady gives pending[i]=1 after 3+DEBOUNCE_CYCLES clocks and req_valid=1 one clock later (8 clocks at default) when the output is idle.
- Wrap: issued/pending are bit vectors; no counters wrap beyond the debounce count.

Optional Feature:
- Macro: FLOOR_CALL_RR_EN.
- Defined: round-robin arbitration. The search starts at (last issued index + 1) mod N_FLOORS and wraps. After reset, the search starts at floor 0.
- Undefined: fixed lowest-index priority as above.

Test Plan:
- Reset and basic call, defaults: hold btn[3]=1 from cycle 0 with req_ready=0 -> pending=8'h08 at cycle 7, req_valid=1 and req_floor=4'd3 at cycle 8 and held stable; req_ready=1 -> transfer, then req_valid=0.
- Glitch rejection: btn[5] high for 3 cycles, then low -> pending stays 0 and req_valid never asserts.
- Priority: floors 6 and 2 pressed the same cycle, req_ready=1 -> req_floor=2 then 6 on consecutive cycles; with FLOOR_CALL_RR_EN and last issued=2, subsequent calls 1 and 6 -> 6 then 1.
- Served clear: after floor 4 is issued, served_valid=1 with served_floor=4 -> pending[4]=0 next cycle; a new press of floor 4 is reissued. served_floor=4'd12 -> no change.
- Simultaneous: served floor 1 on the same cycle as the floor-1 debounced edge -> pending[1] stays 0; a press of an already-pending floor -> no duplicate request.
- Async reset while req_valid=1 -> all outputs 0 immediately, with no clock edge needed.
